// File: rtl/gamma_cycle_sequencer_if.sv
// Host-side operand and result handshakes of the gamma-cycle sequencer.
// The host drives operands and result acceptance; the sequencer answers.
interface gamma_cycle_sequencer_if #(
  parameter int unsigned TW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_time;
  logic          out_fired;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_time, out_fired
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_time, out_fired
  );
endinterface

// File: rtl/gamma_cycle_sequencer.sv
// Runs one race-logic greater-than compare per gamma cycle: local reset,
// level-held operand edges at their encoded ticks, first-spike capture.
module gamma_cycle_sequencer #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned RST_CYCLES        = 1,
  parameter int unsigned TW                = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                          aclk,
  input  logic                          grst,
  gamma_cycle_sequencer_if.slave        host,
  output logic                          gt_rst,
  output logic                          gt_a,
  output logic                          gt_b,
  input  logic                          gt_q
);

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RST_CYCLES - 1);

  // Pulse width belongs to the primitive; only sanity-checked here.
  if (RST_CYCLES < 1 || PULSE_WIDTH < 1) begin : g_cfg_check
    $error("gamma_cycle_sequencer: RST_CYCLES and PULSE_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic [TW-1:0] a_lat, b_lat;
  logic [TW-1:0] out_time_q;
  logic          out_fired_q;

  always_ff @(posedge aclk) begin
    if (grst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    rcnt_nx  = rcnt;
    unique case (state)
      IDLE: begin
        if (host.in_valid) begin
          state_nx = RESET;
          rcnt_nx  = '0;
        end
      end
      RESET: begin
        if (rcnt == RCNT_LAST) begin
          state_nx = RUN;
          tick_nx  = '0;
        end else begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      RUN: begin
        if (tick == TICK_LAST) state_nx = DONE;
        else                   tick_nx  = tick + 1'b1;
      end
      DONE: begin
        if (host.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand edges are computed one cycle ahead from the next tick so that
  // gt_a/gt_b leave the block straight from flops.
  always_ff @(posedge aclk) begin
    if (grst) begin
      tick        <= '0;
      rcnt        <= '0;
      a_lat       <= '0;
      b_lat       <= '0;
      gt_a        <= 1'b0;
      gt_b        <= 1'b0;
      out_time_q  <= '0;
      out_fired_q <= 1'b0;
    end else begin
      tick <= tick_nx;
      rcnt <= rcnt_nx;
      gt_a <= (state_nx == RUN) && (tick_nx >= a_lat);
      gt_b <= (state_nx == RUN) && (tick_nx >= b_lat);
      if (state == IDLE && host.in_valid) begin
        a_lat       <= host.in_a;
        b_lat       <= host.in_b;
        out_time_q  <= '0;
        out_fired_q <= 1'b0;
      end
      if (state == RUN && gt_q && !out_fired_q) begin
        out_time_q  <= tick;
        out_fired_q <= 1'b1;
      end
    end
  end

  always_comb begin
    host.in_ready  = (state == IDLE) && !grst;
    host.out_valid = (state == DONE);
    host.out_time  = out_time_q;
    host.out_fired = out_fired_q;
    gt_rst         = (state == RESET);
  end

endmodule

// File: doc/gamma_cycle_sequencer.md
Name: gamma_cycle_sequencer

Overview:
Sequences one temporal-compare operation per gamma cycle on a race-logic greater-than primitive.
- Accepts two time-encoded operands through a valid/ready handshake.
- Issues the primitive's per-cycle local reset, then drives the operand spike edges at their encoded ticks.
- Captures the tick of the primitive's first output spike and returns it through a valid/ready result port.
- Sits between a host/scheduler and one greater_than instance.

Parameters:
GAMMA_CYCLE_WIDTH, 16, aclk cycles in the RUN phase of one gamma cycle.
PULSE_WIDTH, 8, passed through to the primitive; unused internally.
RST_CYCLES, 1, cycles gt_rst is held high before RUN; must be >= 1.
TW, $clog2(GAMMA_CYCLE_WIDTH)+1, width of time values; a value >= GAMMA_CYCLE_WIDTH means "no spike".

Ports:
aclk  in  1  clock; all logic is on posedge aclk.
grst  in  1  synchronous active-high reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  high in IDLE only, and never while grst is high.
in_a  in  TW  spike time of operand a.
in_b  in  TW  spike time of operand b.
gt_rst  out  1  to primitive rst.
gt_a  out  1  to primitive a.
gt_b  out  1  to primitive b.
gt_q  in  1  primitive output q.
out_valid  out  1  result valid.
out_ready  in  1  result accepted.
out_time  out  TW  tick of the first gt_q sample that was high.
out_fired  out  1  gt_q was seen high during RUN.

Behaviour:
- Reset:
  - grst is sampled at posedge aclk; its effect takes priority over all other behaviour.
  - After the reset edge: state=IDLE; gt_rst=0, gt_a=0, gt_b=0, out_valid=0, out_time=0, out_fired=0.
  - in_ready=0 while grst is high, and 1 in the first cycle after grst falls.
  - If grst arrives mid-operation (RESET/RUN/DONE), the operation is abandoned with no result and the block returns to IDLE.
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE:
  - in_ready=1; the gt_* outputs are all 0.
  - When in_valid&in_ready at an edge: latch in_a and in_b, go to RESET. This handshake cycle is C0.
- RESET (cycles C1..C_R, where R=RST_CYCLES):
  - gt_rst=1, gt_a=0, gt_b=0.
  - gt_q is ignored.
  - After R cycles, go to RUN with tick=0.
- RUN (cycles C_{R+1}..C_{R+G}, where G=GAMMA_CYCLE_WIDTH; tick runs 0..G-1):
  - gt_rst=0.
  - gt_a=1 in every RUN cycle with tick >= a_lat, else 0. gt_b uses b_lat the same way.
  - Operands are level-held: once risen, they stay high until RUN ends.
  - An operand >= G never asserts.
  - gt_a and gt_b must come straight from flops (registered, glitch-free).
  - gt_q is sampled each RUN cycle. On the first sample that is high, record out_time=tick and out_fired=1.
  - Later gt_q activity is ignored.
  - After tick G-1, go to DONE.
- DONE (from cycle C_{R+G+1}):
  - out_valid=1; gt_a=0, gt_b=0.
  - out_time and out_fired are held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE with out_valid=0 the next cycle.
  - in_valid is ignored outside IDLE.
- No-fire result: out_time=0, out_fired=0.
- Throughput and latency:
  - Latency from accept to out_valid is R+G+1 cycles.
  - Minimum spacing between accepts is R+G+2 cycles, with out_ready held high.
- The tick counter saturates in RUN.
- Arithmetic is unsigned. Operand comparisons are at width TW.

Test Plan:
1. Reset release: hold grst high for 2 cycles, then release. -> All outputs 0 during reset; in_ready=1 in the first cycle after release.
2. Fired compare: G=16, R=1, a=3, b=7; bench drives gt_q=1 from tick 3 onward. -> gt_rst high in C1; gt_a high at ticks 3..15; gt_b high at ticks 7..15; out_valid at C18; out_time=3, out_fired=1.
3. No spike: a=16, b=2, gt_q held 0. -> gt_a never asserts; gt_b high at ticks 2..15; out_fired=0, out_time=0.
4. Capture edge cases: gt_q=1 during RESET and again at tick 0, then pulsed at tick 9. -> The RESET sample is ignored; out_time=0, out_fired=1; the tick-9 pulse is ignored.
5. Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1. -> out_valid, out_time and out_fired stay stable; in_ready=0; no new accept. On out_ready=1, return to IDLE, then accept the pending pair.
6. Reset mid-RUN: assert grst at tick 5. -> Next cycle all outputs 0, state IDLE, no out_valid. A following transaction (a=1, b=4) completes normally with out_time set by gt_q.
